// File: rtl/opm_window_acc_if.sv
// ---------------------------------------------------------------------------
// opm_window_acc_if
// Bundles the sample input side and the result valid/ready side of
// opm_window_acc.
//   slave  modport : the accumulator (consumes samples, produces results)
//   master modport : the producer/consumer environment driving it
// Signals:
//   en, clear, pwr_in, thresh    sample qualifier, window restart, power word,
//                                alarm threshold
//   out_valid / out_ready        result handshake
//   win_sum, win_avg, win_peak,
//   over_thresh, overrun_cnt     published window result and overrun count
// ---------------------------------------------------------------------------
interface opm_window_acc_if #(
    parameter int IN_W     = 10,
    parameter int WIN_LOG2 = 4,
    parameter int OVR_W    = 8
);
    logic                     en;
    logic                     clear;
    logic [IN_W-1:0]          pwr_in;
    logic [IN_W-1:0]          thresh;
    logic                     out_valid;
    logic                     out_ready;
    logic [IN_W+WIN_LOG2-1:0] win_sum;
    logic [IN_W-1:0]          win_avg;
    logic [IN_W-1:0]          win_peak;
    logic                     over_thresh;
    logic [OVR_W-1:0]         overrun_cnt;

    modport slave (
        input  en, clear, pwr_in, thresh, out_ready,
        output out_valid, win_sum, win_avg, win_peak, over_thresh, overrun_cnt
    );

    modport master (
        output en, clear, pwr_in, thresh, out_ready,
        input  out_valid, win_sum, win_avg, win_peak, over_thresh, overrun_cnt
    );
endinterface

// File: rtl/opm_window_acc.sv
// ---------------------------------------------------------------------------
// opm_window_acc
// Accumulates the per-cycle power word over windows of 2^WIN_LOG2 accepted
// samples. At window close it publishes sum, average (sum >> WIN_LOG2),
// peak and a threshold flag (avg > thresh) through a valid/ready register.
// A result replaced before acceptance bumps a saturating overrun counter.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, clears all state
//   bus    opm_window_acc_if.slave (see interface file for signal list)
//
// Build option:
//   OPM_PEAK_EN  when defined, the running window maximum is tracked and
//                reported on win_peak; otherwise win_peak is tied to 0.
// ---------------------------------------------------------------------------
module opm_window_acc #(
    parameter int IN_W     = 10,
    parameter int WIN_LOG2 = 4,
    parameter int OVR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    opm_window_acc_if.slave   bus
);
    localparam int SUM_W = IN_W + WIN_LOG2;

    logic [SUM_W-1:0]    acc_reg;
    logic [WIN_LOG2-1:0] cnt_reg;
    logic                out_valid_reg;
    logic [SUM_W-1:0]    win_sum_reg;
    logic                over_thresh_reg;
    logic [OVR_W-1:0]    overrun_reg;

    logic                take_sample;
    logic                win_close;
    logic [SUM_W-1:0]    sum_next;
    logic [IN_W-1:0]     avg_next;

    // clear drops the sample on its cycle and overrides a window close
    assign take_sample = bus.en && !bus.clear;
    assign win_close   = take_sample && (&cnt_reg);
    assign sum_next    = acc_reg + SUM_W'(bus.pwr_in);
    assign avg_next    = sum_next[SUM_W-1:WIN_LOG2];

`ifdef OPM_PEAK_EN
    logic [IN_W-1:0] run_peak_reg;
    logic [IN_W-1:0] win_peak_reg;
    logic [IN_W-1:0] peak_next;

    assign peak_next = (bus.pwr_in > run_peak_reg) ? bus.pwr_in : run_peak_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_peak_reg <= '0;
            win_peak_reg <= '0;
        end else begin
            if (bus.clear || win_close) begin
                run_peak_reg <= '0;
            end else if (take_sample) begin
                run_peak_reg <= peak_next;
            end
            if (win_close) begin
                win_peak_reg <= peak_next;
            end
        end
    end

    assign bus.win_peak = win_peak_reg;
`else
    assign bus.win_peak = '0;
`endif

    // Window accumulator and sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (bus.clear || win_close) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (take_sample) begin
            acc_reg <= sum_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Result register and handshake. A close always loads and keeps valid
    // high; it only counts as an overrun when the held result was not
    // being accepted in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            win_sum_reg     <= '0;
            over_thresh_reg <= 1'b0;
            overrun_reg     <= '0;
        end else if (win_close) begin
            out_valid_reg   <= 1'b1;
            win_sum_reg     <= sum_next;
            over_thresh_reg <= (avg_next > bus.thresh);
            if (out_valid_reg && !bus.out_ready && (overrun_reg != '1)) begin
                overrun_reg <= overrun_reg + 1'b1;
            end
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.win_sum     = win_sum_reg;
    assign bus.win_avg     = win_sum_reg[SUM_W-1:WIN_LOG2];
    assign bus.over_thresh = over_thresh_reg;
    assign bus.overrun_cnt = overrun_reg;

endmodule
